alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 data_valid  in  1  one-cycle strobe from the go capture block (its state_change); qualifies data.
REQ-005 data  in  4  nibble from the go capture block; sampled only when data_valid=1.
REQ-006 ready  out  1  high in LOAD_A, LOAD_B and LOAD_OP; drives wait_led upstream.
REQ-007 stage  out  3  current state code.
REQ-008 result  out  4  registered ALU result.
REQ-009 carry  out  1  registered carry/borrow/shift-out flag.
REQ-010 zero  out  1  registered flag, high when result==0.
REQ-011 err  out  1  registered flag, high for a reserved opcode.
REQ-012 result_valid  out  1  one-cycle pulse when result and flags update.
REQ-013 done_led  out  1  high while in SHOW.

Function
REQ-014 The state machine SHALL use these states: LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4; codes 5-7 SHALL go to LOAD_A on the next edge.
REQ-015 In LOAD_A, LOAD_B and LOAD_OP, data_valid=1 SHALL register data into A, B or OP respectively and advance to the next state on the same edge.
REQ-016 If data_valid=0 in a LOAD state, the block SHALL hold its state and registers.
REQ-017 EXEC SHALL last exactly one cycle; data_valid in EXEC SHALL be ignored.
REQ-018 The EXEC-to-SHOW edge SHALL register result, carry, zero and err, and SHALL assert result_valid for that cycle only.
REQ-019 Latency SHALL be fixed: data_valid in LOAD_OP at edge n gives EXEC after edge n and result_valid high after edge n+1.
REQ-020 SHOW SHALL hold result and flags until the next data_valid.
REQ-021 data_valid in SHOW SHALL return the block to LOAD_A, discard the data nibble, and leave result and flags unchanged until the next EXEC.
REQ-022 Opcodes:
- 0 ADD: A+B, carry = bit 4.
- 1 SUB: A-B mod 16, carry = borrow (A<B).
- 2 AND, 3 OR, 4 XOR: carry=0.
- 5 NOT A: carry=0.
- 6 SHL A: carry=A[3], LSB=0.
- 7 SHR A (logical): carry=A[0].
REQ-023 Opcodes 8-15 SHALL give result=0, carry=0, err=1.
REQ-024 For opcodes 0-7, err SHALL be 0.
REQ-025 All arithmetic SHALL be 4-bit unsigned with wrap-around; no output is wider than declared.
REQ-026 ready and done_led SHALL be decoded from the registered state only; they SHALL NOT depend combinationally on any input.

Reset
REQ-027 Asserting reset at any time, including mid-operation, SHALL immediately force state to LOAD_A and clear A, B, OP, result, carry, zero, err and result_valid.
REQ-028 After reset: stage=0, ready=1, done_led=0, result_valid=0.
REQ-029 The first data_valid after reset deasserts SHALL be taken as operand A.

Structure
REQ-030 State codes and opcode constants SHALL live in a shared package, alu_seq_pkg, so the go block and the top level use the same encodings.
REQ-031 The opcode decode and arithmetic SHALL be a purely combinational sub-module, alu4 (inputs a, b, op; outputs y, c, e); the FSM and output registers stay in alu_sequencer.

Verification
REQ-032 Reset pulse asserted while in LOAD_B SHALL give stage=0, ready=1, result=0, and all flags 0.
REQ-033 Load A=1010, B=0101, OP=0000 SHALL give result=1111, carry=0, zero=0, err=0, with one result_valid pulse two edges after the OP strobe.
REQ-034 Load A=1111, B=0001, OP=0000 SHALL give result=0000, carry=1, zero=1.
REQ-035 Load A=0011, B=0101, OP=0001 SHALL give result=1110, carry=1; then A=0110, B=0011, OP=0111 SHALL give result=0011, carry=0.
REQ-036 Load OP=1001 SHALL give result=0000, err=1, zero=1.
REQ-037 data_valid held high across EXEC SHALL be ignored (stage goes 3 then 4); a later data_valid in SHOW with data=1111 SHALL give stage=0 with result unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU sequencer: FSM state codes and opcodes.
// The go capture block and the top level both import this package.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU: opcode decode, result y, carry c, error e.
// Reserved opcodes (8-15) yield y=0, c=0, e=1.
module alu4
    import alu_seq_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] op,
    output logic [3:0] y,
    output logic       c,
    output logic       e
);

    logic [4:0] sum;
    logic [4:0] diff;

    // bit 4 of the 5-bit difference is the borrow (a < b)
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y = 4'd0;
        c = 1'b0;
        e = 1'b0;
        case (op)
            OP_ADD: begin
                y = sum[3:0];
                c = sum[4];
            end
            OP_SUB: begin
                y = diff[3:0];
                c = diff[4];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_SHL: begin
                y = {a[2:0], 1'b0};
                c = a[3];
            end
            OP_SHR: begin
                y = {1'b0, a[3:1]};
                c = a[0];
            end
            default: e = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Operand/opcode loader FSM around alu4 with registered result and flags.
// Result and flags update only on the EXEC-to-SHOW edge.
module alu_sequencer
    import alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       data_valid,
    input  logic [3:0] data,
    output logic       ready,
    output logic [2:0] stage,
    output logic [3:0] result,
    output logic       carry,
    output logic       zero,
    output logic       err,
    output logic       result_valid,
    output logic       done_led
);

    state_t     state;
    logic [3:0] a_reg;
    logic [3:0] b_reg;
    logic [3:0] op_reg;
    logic [3:0] alu_y;
    logic       alu_c;
    logic       alu_e;

    alu4 u_alu (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .y  (alu_y),
        .c  (alu_c),
        .e  (alu_e)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= LOAD_A;
            a_reg        <= 4'd0;
            b_reg        <= 4'd0;
            op_reg       <= 4'd0;
            result       <= 4'd0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            err          <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                LOAD_A: if (data_valid) begin
                    a_reg <= data;
                    state <= LOAD_B;
                end
                LOAD_B: if (data_valid) begin
                    b_reg <= data;
                    state <= LOAD_OP;
                end
                LOAD_OP: if (data_valid) begin
                    op_reg <= data;
                    state  <= EXEC;
                end
                EXEC: begin
                    result       <= alu_y;
                    carry        <= alu_c;
                    zero         <= (alu_y == 4'd0);
                    err          <= alu_e;
                    result_valid <= 1'b1;
                    state        <= SHOW;
                end
                // nibble arriving in SHOW is only an acknowledge
                SHOW: if (data_valid) state <= LOAD_A;
                default: state <= LOAD_A;
            endcase
        end
    end

    assign stage    = state;
    assign ready    = (state == LOAD_A) || (state == LOAD_B) ||
                      (state == LOAD_OP);
    assign done_led = (state == SHOW);

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed table-driven bench for alu_sequencer plus reset and
// data_valid-across-EXEC sequences.
module tb_alu_sequencer;

    logic       clk;
    logic       reset;
    logic       data_valid;
    logic [3:0] data;
    logic       ready;
    logic [2:0] stage;
    logic [3:0] result;
    logic       carry;
    logic       zero;
    logic       err;
    logic       result_valid;
    logic       done_led;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       e;
    } vec_t;

    vec_t vecs[13];

    alu_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .data_valid   (data_valid),
        .data         (data),
        .ready        (ready),
        .stage        (stage),
        .result       (result),
        .carry        (carry),
        .zero         (zero),
        .err          (err),
        .result_valid (result_valid),
        .done_led     (done_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        @(negedge clk);
        data_valid = 1'b1;
        data       = d;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data       = 4'h0;
    endtask

    task automatic check_flags(input string tag, input vec_t v);
        check({tag, " result"}, {4'h0, result}, {4'h0, v.res});
        check({tag, " carry"}, {7'h0, carry}, {7'h0, v.c});
        check({tag, " zero"}, {7'h0, zero}, {7'h0, v.z});
        check({tag, " err"}, {7'h0, err}, {7'h0, v.e});
    endtask

    task automatic run_vec(input string tag, input vec_t v);
        strobe(v.a);
        check({tag, " stage B"}, {5'h0, stage}, 8'd1);
        strobe(v.b);
        check({tag, " stage OP"}, {5'h0, stage}, 8'd2);
        strobe(v.op);
        check({tag, " stage EXEC"}, {5'h0, stage}, 8'd3);
        check({tag, " rv early"}, {7'h0, result_valid}, 8'd0);
        check({tag, " ready EXEC"}, {7'h0, ready}, 8'd0);
        @(posedge clk);
        #1;
        check({tag, " rv"}, {7'h0, result_valid}, 8'd1);
        check({tag, " stage SHOW"}, {5'h0, stage}, 8'd4);
        check({tag, " done_led"}, {7'h0, done_led}, 8'd1);
        check_flags(tag, v);
        @(posedge clk);
        #1;
        check({tag, " rv pulse"}, {7'h0, result_valid}, 8'd0);
        check_flags({tag, " hold"}, v);
        strobe(4'hF);
        check({tag, " back A"}, {5'h0, stage}, 8'd0);
        check_flags({tag, " ack"}, v);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{4'hA, 4'h5, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'hF, 4'h1, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'h3, 4'h5, 4'h1, 4'hE, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'h6, 4'h3, 4'h7, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'hC, 4'hA, 4'h2, 4'h8, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'hC, 4'hA, 4'h3, 4'hE, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'hC, 4'hA, 4'h4, 4'h6, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'hA, 4'h0, 4'h5, 4'h5, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h9, 4'h0, 4'h6, 4'h2, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'h7, 4'h7, 4'h9, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'hF, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{4'h5, 4'h5, 4'h1, 4'h0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{4'h1, 4'h0, 4'h7, 4'h0, 1'b1, 1'b1, 1'b0};

        reset      = 1'b1;
        data_valid = 1'b0;
        data       = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst stage", {5'h0, stage}, 8'd0);
        check("rst ready", {7'h0, ready}, 8'd1);
        check("rst done", {7'h0, done_led}, 8'd0);
        check("rst rv", {7'h0, result_valid}, 8'd0);
        check("rst result", {4'h0, result}, 8'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // async reset while in LOAD_B with a nonzero held result
        run_vec("pre", vecs[0]);
        strobe(4'h3);
        check("mid stage B", {5'h0, stage}, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid stage", {5'h0, stage}, 8'd0);
        check("mid ready", {7'h0, ready}, 8'd1);
        v = '{4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        check_flags("mid", v);
        check("mid rv", {7'h0, result_valid}, 8'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec("post", vecs[2]);

        // data_valid held high through EXEC
        strobe(4'h2);
        strobe(4'h3);
        @(negedge clk);
        data_valid = 1'b1;
        data       = 4'h0;
        @(posedge clk);
        #1;
        check("hold EXEC", {5'h0, stage}, 8'd3);
        data = 4'h5;
        @(posedge clk);
        #1;
        check("hold SHOW", {5'h0, stage}, 8'd4);
        check("hold rv", {7'h0, result_valid}, 8'd1);
        data_valid = 1'b0;
        v = '{4'h2, 4'h3, 4'h0, 4'h5, 1'b0, 1'b0, 1'b0};
        check_flags("hold", v);
        @(posedge clk);
        #1;
        check("hold stay", {5'h0, stage}, 8'd4);
        strobe(4'hF);
        check("ack stage", {5'h0, stage}, 8'd0);
        check_flags("ack", v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
